// File: rtl/fifo_pkg.sv
// Shared pointer helpers for both sides of the async FIFO.
// Gray/binary conversions operate on a 32-bit word; callers truncate.
package fifo_pkg;

    localparam int PTR_WIDTH_DEF = 3;
    localparam int PW_MAX = 32;

    typedef logic [PW_MAX-1:0] ptr_word_t;

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b[PW_MAX-1] = g[PW_MAX-1];
        for (int i = PW_MAX-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for Gray pointers crossing clock domains.
// Every stage clears on the asynchronous reset.
module sync_ff #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer, full/almost-full, level and overflow control
// for the dual-clock FIFO.
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH    = PTR_WIDTH_DEF,
    parameter int AFULL_THRESH = 6,
    parameter int SYNC_STAGES  = 2
) (
    input  logic               wclk,
    input  logic               wrst,
    input  logic               w_en,
    input  logic               ovf_clr,
    input  logic [PTR_WIDTH:0] g_rptr,
    output logic [PTR_WIDTH:0] b_wptr,
    output logic [PTR_WIDTH:0] g_wptr,
    output logic               full,
    output logic               almost_full,
    output logic [PTR_WIDTH:0] wr_level,
    output logic               overflow
);

    localparam int PW = PTR_WIDTH + 1;
    localparam logic [PW-1:0] AF_T = PW'(AFULL_THRESH);

    logic [PW-1:0] rq;
    logic [PW-1:0] rq_lap;
    logic [PW-1:0] rbin;
    logic [PW-1:0] b_next;
    logic [PW-1:0] g_next;
    logic [PW-1:0] lvl_next;
    logic          wr_fire;

    sync_ff #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk (wclk),
        .rst (wrst),
        .d   (g_rptr),
        .q   (rq)
    );

    assign wr_fire  = w_en & ~full;
    assign b_next   = b_wptr + PW'(wr_fire);
    assign g_next   = PW'(bin2gray(PW_MAX'(b_next)));
    assign rbin     = PW'(gray2bin(PW_MAX'(rq)));
    assign lvl_next = b_next - rbin;
    // Write pointer one full lap ahead of the synced read pointer.
    assign rq_lap   = {~rq[PW-1], ~rq[PW-2], rq[PW-3:0]};

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            b_wptr      <= '0;
            g_wptr      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            b_wptr      <= b_next;
            g_wptr      <= g_next;
            full        <= (g_next == rq_lap);
            almost_full <= (lvl_next >= AF_T);
            wr_level    <= lvl_next;
            if (w_en && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl: vector table plus reset and
// wrap-around sequences.
module tb_wptr_full_ctrl;

    logic       wclk;
    logic       wrst;
    logic       w_en;
    logic       ovf_clr;
    logic [3:0] g_rptr;
    logic [3:0] b_wptr;
    logic [3:0] g_wptr;
    logic       full;
    logic       almost_full;
    logic [3:0] wr_level;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    wptr_full_ctrl #(
        .PTR_WIDTH    (3),
        .AFULL_THRESH (6),
        .SYNC_STAGES  (2)
    ) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .w_en        (w_en),
        .ovf_clr     (ovf_clr),
        .g_rptr      (g_rptr),
        .b_wptr      (b_wptr),
        .g_wptr      (g_wptr),
        .full        (full),
        .almost_full (almost_full),
        .wr_level    (wr_level),
        .overflow    (overflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        logic       we;
        logic       clr;
        logic [3:0] grp;
        logic [3:0] b;
        logic [3:0] g;
        logic       f;
        logic       af;
        logic [3:0] lvl;
        logic       ovf;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic we, input logic clr, input logic [3:0] grp,
        input logic [3:0] b, input logic [3:0] g, input logic f,
        input logic af, input logic [3:0] lvl, input logic ovf);
        vec_t v;
        v.we = we; v.clr = clr; v.grp = grp;
        v.b = b; v.g = g; v.f = f;
        v.af = af; v.lvl = lvl; v.ovf = ovf;
        return v;
    endfunction

    function automatic logic [3:0] tgray(input int x);
        logic [3:0] v;
        v = 4'(x);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, " b_wptr"}, int'(b_wptr), int'(v.b));
        chk({tag, " g_wptr"}, int'(g_wptr), int'(v.g));
        chk({tag, " full"}, int'(full), int'(v.f));
        chk({tag, " almost_full"}, int'(almost_full), int'(v.af));
        chk({tag, " wr_level"}, int'(wr_level), int'(v.lvl));
        chk({tag, " overflow"}, int'(overflow), int'(v.ovf));
    endtask

    initial begin
        // fill with g_rptr at 0
        vecs[0]  = mk(1, 0, 4'h0, 4'd1, 4'b0001, 0, 0, 4'd1, 0);
        vecs[1]  = mk(1, 0, 4'h0, 4'd2, 4'b0011, 0, 0, 4'd2, 0);
        vecs[2]  = mk(1, 0, 4'h0, 4'd3, 4'b0010, 0, 0, 4'd3, 0);
        vecs[3]  = mk(1, 0, 4'h0, 4'd4, 4'b0110, 0, 0, 4'd4, 0);
        vecs[4]  = mk(1, 0, 4'h0, 4'd5, 4'b0111, 0, 0, 4'd5, 0);
        vecs[5]  = mk(1, 0, 4'h0, 4'd6, 4'b0101, 0, 1, 4'd6, 0);
        vecs[6]  = mk(1, 0, 4'h0, 4'd7, 4'b0100, 0, 1, 4'd7, 0);
        vecs[7]  = mk(1, 0, 4'h0, 4'd8, 4'b1100, 1, 1, 4'd8, 0);
        // writes while full
        vecs[8]  = mk(1, 0, 4'h0, 4'd8, 4'b1100, 1, 1, 4'd8, 1);
        vecs[9]  = mk(1, 0, 4'h0, 4'd8, 4'b1100, 1, 1, 4'd8, 1);
        vecs[10] = mk(1, 0, 4'h0, 4'd8, 4'b1100, 1, 1, 4'd8, 1);
        vecs[11] = mk(0, 1, 4'h0, 4'd8, 4'b1100, 1, 1, 4'd8, 0);
        vecs[12] = mk(1, 1, 4'h0, 4'd8, 4'b1100, 1, 1, 4'd8, 1);
        vecs[13] = mk(0, 1, 4'h0, 4'd8, 4'b1100, 1, 1, 4'd8, 0);
        // read pointer to 1: visible after three edges
        vecs[14] = mk(0, 0, 4'b0001, 4'd8, 4'b1100, 1, 1, 4'd8, 0);
        vecs[15] = mk(0, 0, 4'b0001, 4'd8, 4'b1100, 1, 1, 4'd8, 0);
        vecs[16] = mk(0, 0, 4'b0001, 4'd8, 4'b1100, 0, 1, 4'd7, 0);
        // threshold crossing 7 -> 6 -> 5 -> 6 -> 5
        vecs[17] = mk(0, 0, 4'b0011, 4'd8, 4'b1100, 0, 1, 4'd7, 0);
        vecs[18] = mk(0, 0, 4'b0011, 4'd8, 4'b1100, 0, 1, 4'd7, 0);
        vecs[19] = mk(0, 0, 4'b0011, 4'd8, 4'b1100, 0, 1, 4'd6, 0);
        vecs[20] = mk(0, 0, 4'b0010, 4'd8, 4'b1100, 0, 1, 4'd6, 0);
        vecs[21] = mk(0, 0, 4'b0010, 4'd8, 4'b1100, 0, 1, 4'd6, 0);
        vecs[22] = mk(0, 0, 4'b0010, 4'd8, 4'b1100, 0, 0, 4'd5, 0);
        vecs[23] = mk(1, 0, 4'b0010, 4'd9, 4'b1101, 0, 1, 4'd6, 0);
        vecs[24] = mk(0, 0, 4'b0110, 4'd9, 4'b1101, 0, 1, 4'd6, 0);
        vecs[25] = mk(0, 0, 4'b0110, 4'd9, 4'b1101, 0, 1, 4'd6, 0);
        vecs[26] = mk(0, 0, 4'b0110, 4'd9, 4'b1101, 0, 0, 4'd5, 0);

        wrst = 1'b1;
        w_en = 1'b0;
        ovf_clr = 1'b0;
        g_rptr = 4'h0;
        #12;
        chk("reset b_wptr", int'(b_wptr), 0);
        chk("reset g_wptr", int'(g_wptr), 0);
        chk("reset full", int'(full), 0);
        chk("reset almost_full", int'(almost_full), 0);
        chk("reset wr_level", int'(wr_level), 0);
        chk("reset overflow", int'(overflow), 0);
        @(negedge wclk);
        wrst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            w_en    = vecs[i].we;
            ovf_clr = vecs[i].clr;
            g_rptr  = vecs[i].grp;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i]);
        end

        // async reset between edges, outputs clear without a clock
        w_en = 1'b1;
        ovf_clr = 1'b0;
        tick();
        tick();
        wrst = 1'b1;
        #1;
        chk("async b_wptr", int'(b_wptr), 0);
        chk("async g_wptr", int'(g_wptr), 0);
        chk("async wr_level", int'(wr_level), 0);
        chk("async almost_full", int'(almost_full), 0);
        g_rptr = 4'h0;
        #1;
        wrst = 1'b0;
        w_en = 1'b1;
        tick();
        chk("post-reset b_wptr", int'(b_wptr), 1);
        chk("post-reset g_wptr", int'(g_wptr), 4'b0001);

        // wrap: reader trails by at most 4 words
        begin
            int  full_seen;
            int  wr;
            full_seen = 0;
            wr = 1;
            for (int i = 0; i < 19; i++) begin
                g_rptr = tgray((wr > 4) ? wr - 4 : 0);
                w_en = 1'b1;
                tick();
                wr++;
                if (full) full_seen++;
            end
            chk("wrap b_wptr", int'(b_wptr), 4'b0100);
            chk("wrap g_wptr", int'(g_wptr), 4'b0110);
            chk("wrap full never", full_seen, 0);
            w_en = 1'b0;
            g_rptr = 4'b0110;
            tick();
            tick();
            tick();
            chk("wrap drained level", int'(wr_level), 0);
            chk("wrap drained af", int'(almost_full), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
